// File: rtl/bpsk_mod_pkg.sv
// Shared constants and the elaboration-time sine generator for the BPSK modulator.
// Sine values are built from a quadrant-folded Taylor series so only basic real arithmetic is needed.
package bpsk_mod_pkg;

    localparam real PI = 3.14159265358979323846;

    function automatic int lut_depth(input int aw);
        lut_depth = 1 << aw;
    endfunction

    // Symmetric amplitude: the most-negative code is never produced, so negation cannot overflow.
    function automatic int lut_amp(input int dw);
        lut_amp = (1 << (dw - 1)) - 1;
    endfunction

    function automatic int sine_entry(input int k, input int aw, input int dw);
        int  n;
        int  kk;
        bit  neg;
        real x;
        real term;
        real acc;
        n    = lut_depth(aw);
        kk   = k % n;
        neg  = (kk >= n / 2);
        kk   = kk % (n / 2);
        if (kk > n / 4) begin
            kk = n / 2 - kk;
        end
        x    = 2.0 * PI * real'(kk) / real'(n);
        term = x;
        acc  = x;
        for (int i = 1; i < 12; i++) begin
            term = -term * x * x / real'((2 * i) * (2 * i + 1));
            acc  = acc + term;
        end
        sine_entry = $rtoi(real'(lut_amp(dw)) * acc + 0.5);
        if (neg) begin
            sine_entry = -sine_entry;
        end
    endfunction

endpackage

// File: rtl/bpsk_mod_sine_lut.sv
// One-period sine ROM, contents fixed at elaboration, combinational read.
module sine_lut
    import bpsk_mod_pkg::*;
#(
    parameter int DATA_WIDTH = 12,
    parameter int ADDR_WIDTH = 8
) (
    input  logic [ADDR_WIDTH-1:0]        addr,
    output logic signed [DATA_WIDTH-1:0] data
);

    localparam int DEPTH = lut_depth(ADDR_WIDTH);

    logic signed [DATA_WIDTH-1:0] rom [DEPTH];

    for (genvar k = 0; k < DEPTH; k++) begin : g_rom
        localparam logic signed [DATA_WIDTH-1:0] ENTRY =
            DATA_WIDTH'(sine_entry(k, ADDR_WIDTH, DATA_WIDTH));
        assign rom[k] = ENTRY;
    end

    assign data = rom[addr];

endmodule

// File: rtl/bpsk_mod.sv
// BPSK modulator: free-running phase counter into a sine ROM, sign selected by the data bit, registered output.
module bpsk_mod
    import bpsk_mod_pkg::*;
#(
    parameter int DATA_WIDTH = 12,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         arst,
    input  logic                         en,
    input  logic                         s,
    output logic signed [DATA_WIDTH-1:0] signal_out
);

    logic [ADDR_WIDTH-1:0]        addr;
    logic signed [DATA_WIDTH-1:0] lut_data;
    logic signed [DATA_WIDTH-1:0] neg_data;

    sine_lut #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_sine_lut (
        .addr(addr),
        .data(lut_data)
    );

    assign neg_data = -lut_data;

    // The counter wraps naturally at 2^ADDR_WIDTH; a change of s never touches it.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            addr       <= '0;
            signal_out <= '0;
        end else if (en) begin
            addr       <= addr + ADDR_WIDTH'(1);
            signal_out <= s ? lut_data : neg_data;
        end
    end

endmodule

// File: tb/tb_bpsk_mod.sv
// Self-checking bench for bpsk_mod: golden sine model built with $sin, scoreboard queue of expected samples.
module tb_bpsk_mod;

    localparam int DW = 12;
    localparam int AW = 8;
    localparam int N  = 256;

    logic                 clk;
    logic                 arst;
    logic                 en;
    logic                 s;
    logic signed [DW-1:0] signal_out;

    int compared   = 0;
    int mismatched = 0;

    int            lut_m [N];
    int            m_addr;
    int            m_out;
    logic [DW-1:0] exp_q[$];
    int            hist [0:400];

    bpsk_mod #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk),
        .arst(arst),
        .en(en),
        .s(s),
        .signal_out(signal_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic build_model();
        real r;
        for (int k = 0; k < N; k++) begin
            r = 2047.0 * $sin(2.0 * 3.14159265358979323846 * real'(k) / real'(N));
            lut_m[k] = (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
        end
    endtask

    // Drives one cycle; pushes the expected output for the coming edge, returns at posedge+1.
    task automatic step(input logic en_v, input logic s_v);
        en = en_v;
        s  = s_v;
        if (en_v) begin
            m_out  = s_v ? lut_m[m_addr] : -lut_m[m_addr];
            m_addr = (m_addr + 1) % N;
        end
        exp_q.push_back(DW'(m_out));
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        arst = 1'b0;
        en   = 1'b0;
        s    = 1'b0;
        @(posedge clk);
        #1;
        arst   = 1'b1;
        m_addr = 0;
        m_out  = 0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        arst = 1'b0;
        #1;
        for (int i = 0; i < 6; i++) begin
            en = 1'($urandom_range(0, 1));
            s  = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            compared++;
            if (signal_out !== '0) begin
                mismatched++;
                $display("FAIL reset_out cycle %0d: got %0d want 0", i, signal_out);
            end
            compared++;
            if (dut.addr !== '0) begin
                mismatched++;
                $display("FAIL reset_addr cycle %0d: got %0d want 0", i, dut.addr);
            end
        end
        apply_reset();
    endtask

    task automatic test_carrier(input logic sv);
        logic [DW-1:0] e;
        int            sign;
        int            edges [5];
        int            vals [5];
        edges = '{1, 33, 65, 129, 193};
        vals  = '{0, 1447, 2047, 0, -2047};
        sign  = sv ? 1 : -1;
        apply_reset();
        for (int n = 1; n <= N; n++) begin
            step(1'b1, sv);
            e = exp_q.pop_front();
            hist[n] = int'(signal_out);
            compared++;
            if (signal_out !== e) begin
                mismatched++;
                $display("FAIL carrier_s%0d edge %0d: got %0d want %0d", sv, n, signal_out, $signed(e));
            end
        end
        for (int i = 0; i < 5; i++) begin
            compared++;
            if (hist[edges[i]] !== sign * vals[i]) begin
                mismatched++;
                $display("FAIL carrier_s%0d_const edge %0d: got %0d want %0d", sv, edges[i], hist[edges[i]], sign * vals[i]);
            end
        end
    endtask

    task automatic test_phase_toggle();
        logic [DW-1:0] e;
        apply_reset();
        for (int n = 1; n <= 66; n++) begin
            step(1'b1, (n <= 65));
            e = exp_q.pop_front();
            hist[n] = int'(signal_out);
            compared++;
            if (signal_out !== e) begin
                mismatched++;
                $display("FAIL toggle edge %0d: got %0d want %0d", n, signal_out, $signed(e));
            end
        end
        compared++;
        if (hist[65] !== 2047 || hist[66] !== -2046) begin
            mismatched++;
            $display("FAIL toggle_jump: got %0d -> %0d want 2047 -> -2046", hist[65], hist[66]);
        end
    endtask

    task automatic test_wrap();
        logic [DW-1:0] e;
        apply_reset();
        for (int n = 1; n <= 321; n++) begin
            step(1'b1, 1'b1);
            e = exp_q.pop_front();
            hist[n] = int'(signal_out);
            compared++;
            if (signal_out !== e) begin
                mismatched++;
                $display("FAIL wrap edge %0d: got %0d want %0d", n, signal_out, $signed(e));
            end
        end
        compared++;
        if (hist[256] !== -50 || hist[257] !== 0 || hist[258] !== 50 || hist[321] !== 2047) begin
            mismatched++;
            $display("FAIL wrap_const: got %0d %0d %0d %0d want -50 0 50 2047",
                     hist[256], hist[257], hist[258], hist[321]);
        end
    endtask

    task automatic test_enable();
        logic [DW-1:0] e;
        logic [AW-1:0] frozen_addr;
        apply_reset();
        for (int n = 0; n < 70; n++) begin
            step((n < 40 || n >= 50), 1'b1);
            e = exp_q.pop_front();
            compared++;
            if (signal_out !== e) begin
                mismatched++;
                $display("FAIL enable cycle %0d: got %0d want %0d", n, signal_out, $signed(e));
            end
            if (n == 40) frozen_addr = dut.addr;
            if (n == 49) begin
                compared++;
                if (dut.addr !== frozen_addr || dut.addr !== AW'(40)) begin
                    mismatched++;
                    $display("FAIL enable_addr_hold: got %0d want 40", dut.addr);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] e;
        apply_reset();
        for (int n = 0; n < 512; n++) begin
            step(($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)));
            e = exp_q.pop_front();
            compared++;
            if (signal_out !== e) begin
                mismatched++;
                $display("FAIL random cycle %0d: got %0d want %0d", n, signal_out, $signed(e));
            end
            compared++;
            if (signal_out > 2047 || signal_out < -2047) begin
                mismatched++;
                $display("FAIL random_range cycle %0d: got %0d want |v|<=2047", n, signal_out);
            end
        end
        // Asynchronous reset between edges must clear the output without a clock.
        en = 1'b1;
        #2;
        arst = 1'b0;
        #1;
        compared++;
        if (signal_out !== '0 || dut.addr !== '0) begin
            mismatched++;
            $display("FAIL async_reset: got out %0d addr %0d want 0 0", signal_out, dut.addr);
        end
        @(posedge clk);
        #1;
        apply_reset();
    endtask

    initial begin
        arst   = 1'b0;
        en     = 1'b0;
        s      = 1'b0;
        m_addr = 0;
        m_out  = 0;
        build_model();
        test_reset();
        test_carrier(1'b1);
        test_carrier(1'b0);
        test_phase_toggle();
        test_wrap();
        test_enable();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
